// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : aes_pkg
//  Purpose  : Shared types and constants for the AES-128 word-stream adapter
//  Revision : 1.0  initial release
// ============================================================================
package aes_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_block_t;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } aes_adp_state_e;

endpackage
`default_nettype wire

// File: rtl/aes_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : aes_stream_adapter
//  Purpose  : Packs a word stream into one 128-bit block, runs a single
//             AES-128 encryption on the attached core, and unpacks the
//             ciphertext onto a valid/ready word stream. One block in flight.
//  Revision : 1.0  initial release
// ============================================================================
module aes_stream_adapter
    import aes_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [127:0]      key_in,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              core_start,
    output logic [127:0]      core_plaintext,
    output logic [127:0]      core_key,
    input  logic [127:0]      core_ciphertext,
    input  logic              core_done,
    output logic              busy,
    output logic              err_timeout
);

    localparam int c_NW    = AES_BLOCK_W / WORD_W;
    localparam int c_CNT_W = (c_NW > 1) ? $clog2(c_NW) : 1;
    localparam int c_TMO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [c_CNT_W-1:0] c_LAST_WORD = c_CNT_W'(c_NW - 1);
    localparam logic [c_TMO_W-1:0] c_TMO_LAST  = c_TMO_W'(TIMEOUT_CYC - 1);

    aes_adp_state_e     r_state;
    aes_adp_state_e     w_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_TMO_W-1:0] r_tmo;
    aes_block_t         r_in;
    aes_block_t         r_out;
    aes_block_t         r_key;
    logic               r_err;
    logic               w_s_fire;
    logic               w_m_fire;
    logic               w_cnt_last;

    assign w_s_fire   = s_valid & s_ready;
    assign w_m_fire   = m_valid & m_ready;
    assign w_cnt_last = (r_cnt == c_LAST_WORD);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/strobe decode
    always_comb begin
        w_next     = r_state;
        s_ready    = 1'b0;
        core_start = 1'b0;
        m_valid    = 1'b0;
        m_last     = 1'b0;
        case (r_state)
            FILL: begin
                // Held low while reset is asserted so nothing is taken mid-reset.
                s_ready = ~reset;
                if (s_valid && w_cnt_last) begin
                    w_next = START;
                end
            end
            START: begin
                core_start = 1'b1;
                w_next     = WAIT;
            end
            WAIT: begin
                // A done arriving on the last permitted cycle still counts.
                if (core_done) begin
                    w_next = DRAIN;
                end else if (r_tmo == c_TMO_LAST) begin
                    w_next = FILL;
                end
            end
            DRAIN: begin
                m_valid = 1'b1;
                m_last  = w_cnt_last;
                if (m_ready && w_cnt_last) begin
                    w_next = FILL;
                end
            end
            default: begin
                w_next = FILL;
            end
        endcase
    end

    // Datapath: input packing, key latch, timeout counting, output unpacking
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_tmo <= '0;
            r_in  <= '0;
            r_out <= '0;
            r_key <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                FILL: begin
                    if (w_s_fire) begin
                        r_in  <= {r_in[AES_BLOCK_W-WORD_W-1:0], s_data};
                        r_cnt <= w_cnt_last ? '0 : r_cnt + c_CNT_W'(1);
                    end
                end
                START: begin
                    r_key <= key_in;
                    r_tmo <= '0;
                end
                WAIT: begin
                    if (core_done) begin
                        r_out <= core_ciphertext;
                        r_tmo <= '0;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_err <= 1'b1;
                        r_tmo <= '0;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end
                DRAIN: begin
                    if (w_m_fire) begin
                        r_out <= {r_out[AES_BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
                        r_cnt <= w_cnt_last ? '0 : r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // The core sees the live key during the start pulse, the latched copy after.
    assign core_key       = (r_state == START) ? key_in : r_key;
    assign core_plaintext = r_in;
    assign m_data         = r_out[AES_BLOCK_W-1 -: WORD_W];
    assign busy           = ~((r_state == FILL) && (r_cnt == '0));
    assign err_timeout    = r_err;

endmodule
`default_nettype wire
